// File: rtl/crc_mem_pkg.sv
// Shared definitions for the CRC-protected memory: FSM encoding and width helpers.
package crc_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_SHIFT,
        ST_W_COMMIT,
        ST_R_FETCH,
        ST_R_SHIFT,
        ST_R_CHECK
    } state_t;

    function automatic int codeword_width(input int data_w, input int crc_w);
        return data_w + crc_w;
    endfunction

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/crc_serial_engine.sv
// Bit-serial CRC LFSR, MSB-first, shared by the encode and check paths.
module crc_serial_engine #(
    parameter int              CRC_W = 4,
    parameter logic [CRC_W-1:0] POLY = 'h3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] crc_reg;
    logic             fb;

    assign fb  = crc_reg[CRC_W-1] ^ bit_in;
    assign crc = crc_reg;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            crc_reg <= '0;
        end else if (shift_en) begin
            crc_reg <= {crc_reg[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

endmodule

// File: rtl/crc_param_memory.sv
// CRC-protected memory: serial encode on write, serial recheck on read, with
// req/ready handshake, saturating error counter and last-error address capture.
module crc_param_memory
    import crc_mem_pkg::*;
#(
    parameter int               DATA_W  = 8,
    parameter int               ADDR_W  = 4,
    parameter int               CRC_W   = 4,
    parameter logic [CRC_W-1:0] POLY    = 'h3,
    parameter int               COUNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_req,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic [DATA_W+CRC_W-1:0]   fault_mask,
    input  logic                      rd_req,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic                      ready,
    output logic                      wr_done,
    output logic                      rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_error,
    output logic [COUNT_W-1:0]        err_count,
    output logic [ADDR_W-1:0]         last_err_addr
);

    localparam int CW    = codeword_width(DATA_W, CRC_W);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_t state_reg, state_next;

    logic [CNT_W-1:0]   bit_cnt_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [DATA_W-1:0]  data_reg;
    logic [CW-1:0]      mask_reg;
    logic [CW-1:0]      fetch_reg;
    logic [CW-1:0]      mem_reg [DEPTH];

    logic               wr_done_reg;
    logic               rd_valid_reg;
    logic [DATA_W-1:0]  rd_data_reg;
    logic               rd_error_reg;
    logic [COUNT_W-1:0] err_count_reg;
    logic [ADDR_W-1:0]  last_err_addr_reg;

    logic [DATA_W-1:0]  payload;
    logic               eng_clear;
    logic               eng_shift;
    logic               eng_bit;
    logic [CRC_W-1:0]   crc;
    logic               crc_bad;
    logic               last_bit;

    // The engine sits cleared in IDLE so each operation starts from an all-zero LFSR.
    assign payload   = (state_reg == ST_W_SHIFT) ? data_reg : fetch_reg[CW-1:CRC_W];
    assign eng_clear = (state_reg == ST_IDLE);
    assign eng_shift = (state_reg == ST_W_SHIFT) || (state_reg == ST_R_SHIFT);
    assign eng_bit   = payload[CNT_LAST - bit_cnt_reg];
    assign last_bit  = (bit_cnt_reg == CNT_LAST);
    assign crc_bad   = (crc != fetch_reg[CRC_W-1:0]);

    crc_serial_engine #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_engine (
        .clk      (clk),
        .rst      (rst),
        .clear    (eng_clear),
        .shift_en (eng_shift),
        .bit_in   (eng_bit),
        .crc      (crc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (wr_req) begin
                    state_next = ST_W_SHIFT;
                end else if (rd_req) begin
                    state_next = ST_R_FETCH;
                end
            end
            ST_W_SHIFT:  if (last_bit) state_next = ST_W_COMMIT;
            ST_W_COMMIT: state_next = ST_IDLE;
            ST_R_FETCH:  state_next = ST_R_SHIFT;
            ST_R_SHIFT:  if (last_bit) state_next = ST_R_CHECK;
            ST_R_CHECK:  state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Storage: reset clears every entry, which is a valid codeword because CRC(0)=0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (state_reg == ST_W_COMMIT) begin
            mem_reg[addr_reg] <= {data_reg, crc} ^ mask_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt_reg       <= '0;
            addr_reg          <= '0;
            data_reg          <= '0;
            mask_reg          <= '0;
            fetch_reg         <= '0;
            wr_done_reg       <= 1'b0;
            rd_valid_reg      <= 1'b0;
            rd_data_reg       <= '0;
            rd_error_reg      <= 1'b0;
            err_count_reg     <= '0;
            last_err_addr_reg <= '0;
        end else begin
            wr_done_reg  <= 1'b0;
            rd_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    bit_cnt_reg <= '0;
                    if (wr_req) begin
                        addr_reg <= wr_addr;
                        data_reg <= wr_data;
                        mask_reg <= fault_mask;
                    end else if (rd_req) begin
                        addr_reg <= rd_addr;
                    end
                end
                ST_W_SHIFT, ST_R_SHIFT: begin
                    bit_cnt_reg <= bit_cnt_reg + 1'b1;
                end
                ST_W_COMMIT: begin
                    wr_done_reg <= 1'b1;
                end
                ST_R_FETCH: begin
                    fetch_reg <= mem_reg[addr_reg];
                end
                ST_R_CHECK: begin
                    rd_valid_reg <= 1'b1;
                    rd_data_reg  <= fetch_reg[CW-1:CRC_W];
                    rd_error_reg <= crc_bad;
                    if (crc_bad) begin
                        last_err_addr_reg <= addr_reg;
                        if (err_count_reg != '1) begin
                            err_count_reg <= err_count_reg + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready         = (state_reg == ST_IDLE);
    assign wr_done       = wr_done_reg;
    assign rd_valid      = rd_valid_reg;
    assign rd_data       = rd_data_reg;
    assign rd_error      = rd_error_reg;
    assign err_count     = err_count_reg;
    assign last_err_addr = last_err_addr_reg;

endmodule

// File: tb/tb_crc_param_memory.sv
// Directed bench for crc_param_memory: read results checked through an expected-value queue.
module tb_crc_param_memory;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 4;
    localparam int CRC_W   = 4;
    localparam int CW      = DATA_W + CRC_W;
    localparam int COUNT_W = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [CW-1:0]     fault_mask = '0;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              ready;
    logic              wr_done;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_error;
    logic [COUNT_W-1:0] err_count;
    logic [ADDR_W-1:0] last_err_addr;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } exp_t;

    exp_t          exp_q[$];
    logic [CW-1:0] model_mem [16];

    crc_param_memory #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .CRC_W   (CRC_W),
        .POLY    (4'h3),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .fault_mask    (fault_mask),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .ready         (ready),
        .wr_done       (wr_done),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_error      (rd_error),
        .err_count     (err_count),
        .last_err_addr (last_err_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [CRC_W-1:0] crc_of(input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ d[i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
    endtask

    always @(negedge clk) begin
        if (rst && rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rd_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rd_data", 32'(rd_data), 32'(e.data));
                chk("rd_error", 32'(rd_error), 32'(e.err));
                $display("read: data=%h err=%0d (expected %h/%0d)", rd_data, rd_error, e.data, e.err);
            end
        end
    end

    // Caller is #1 after a posedge with the DUT idle.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic [CW-1:0] m);
        int cyc;
        chk("ready_before_write", 32'(ready), 32'd1);
        wr_req = 1'b1; wr_addr = a; wr_data = d; fault_mask = m;
        @(posedge clk); #1;
        wr_req = 1'b0; fault_mask = '0;
        model_mem[a] = {d, crc_of(d)} ^ m;
        cyc = 0;
        while (!wr_done && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        chk("wr_done_latency", 32'(cyc), 32'(DATA_W + 1));
        $display("write: addr=%0d data=%h mask=%h latency=%0d", a, d, m, cyc);
    endtask

    task automatic push_read_exp(input logic [ADDR_W-1:0] a);
        exp_t          e;
        logic [CW-1:0] w;
        w      = model_mem[a];
        e.data = w[CW-1:CRC_W];
        e.err  = (crc_of(w[CW-1:CRC_W]) != w[CRC_W-1:0]);
        exp_q.push_back(e);
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a);
        int cyc;
        chk("ready_before_read", 32'(ready), 32'd1);
        push_read_exp(a);
        rd_req = 1'b1; rd_addr = a;
        @(posedge clk); #1;
        rd_req = 1'b0;
        cyc = 0;
        while (!rd_valid && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        chk("rd_valid_latency", 32'(cyc), 32'(DATA_W + 2));
    endtask

    initial begin
        int cyc;
        int seen;

        // T1: reset state and a read of untouched memory
        model_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_wr_done", 32'(wr_done), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_rd_error", 32'(rd_error), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_last_err_addr", 32'(last_err_addr), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        do_read(4'd3);

        // T2: clean write/read round trip
        do_write(4'd5, 8'hA5, '0);
        chk("stored_codeword", 32'(dut.mem_reg[5]), 32'h0A5B);
        do_read(4'd5);
        chk("t2_err_count", 32'(err_count), 32'd0);

        // T3: injected single-bit fault in the CRC field
        do_write(4'd2, 8'hA5, 12'h001);
        do_read(4'd2);
        chk("t3_err_count", 32'(err_count), 32'd1);
        chk("t3_last_err_addr", 32'(last_err_addr), 32'd2);

        // T4: simultaneous requests -- write first, pending read returns new data
        chk("t4_ready", 32'(ready), 32'd1);
        wr_req = 1'b1; wr_addr = 4'd9; wr_data = 8'h3C;
        rd_req = 1'b1; rd_addr = 4'd9;
        @(posedge clk); #1;
        wr_req = 1'b0;
        model_mem[9] = {8'h3C, crc_of(8'h3C)};
        push_read_exp(4'd9);
        cyc = 0;
        while (!wr_done && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        chk("t4_wr_done_latency", 32'(cyc), 32'(DATA_W + 1));
        @(posedge clk); #1;
        chk("t4_read_accepted", 32'(ready), 32'd0);
        rd_req = 1'b0;
        cyc = 0;
        while (!rd_valid && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        chk("t4_rd_valid_latency", 32'(cyc), 32'(DATA_W + 2));

        // T6: reset during W_SHIFT aborts the write
        chk("t6_ready", 32'(ready), 32'd1);
        wr_req = 1'b1; wr_addr = 4'd7; wr_data = 8'hFF;
        @(posedge clk); #1;
        wr_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        chk("t6_ready_after_rst", 32'(ready), 32'd1);
        chk("t6_err_count_cleared", 32'(err_count), 32'd0);
        seen = 0;
        repeat (12) begin
            if (wr_done) seen++;
            @(posedge clk); #1;
        end
        chk("t6_no_wr_done", 32'(seen), 32'd0);
        chk("t6_mem7", 32'(dut.mem_reg[7]), 32'd0);
        do_read(4'd7);

        // T5: error counter saturates at all-ones
        do_write(4'd1, 8'h5A, 12'h010);
        for (int i = 0; i < 5; i++) begin
            do_read(4'd1);
            chk("t5_err_count", 32'(err_count), (i < 3) ? 32'(i + 1) : 32'd3);
            chk("t5_last_err_addr", 32'(last_err_addr), 32'd1);
        end

        @(negedge clk); @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
